approx_dot_accum: RTL and testbench

- Downstream consumer of the radix-4 approximate 32x32 multiplier (radix4approx). Accepts its 64-bit products over a valid/ready handshake.
- Sums a programmed number of products into a wide accumulator, then presents the dot-product result with a sticky overflow flag.
- Sits between the combinational multiplier and the result/error-analysis logic. Gives the multiplier a registered, flow-controlled sink.

---
 rtl/approx_mult_pkg.sv | 34 +++
 rtl/approx_dot_accum.sv | 123 ++++++++++++
 tb/tb_approx_dot_accum.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mult_pkg
//  Description : Shared definitions for the radix-4 approximate multiplier
//                family. Holds the operand/product widths, the accumulator
//                FSM state encoding and small valid/ready helpers.
//  Contents    : MULT_OP_W, MULT_PROD_W, HS_ASSERT/HS_DEASSERT,
//                acc_state_e, hs_fire()
//  Revision    : 1.0 - initial release
// ============================================================================
package approx_mult_pkg;

  // Operand width of the radix-4 multiplier and its full product width.
  localparam int MULT_OP_W   = 32;
  localparam int MULT_PROD_W = 2 * MULT_OP_W;

  // Handshake levels shared by the radix blocks.
  localparam logic HS_ASSERT   = 1'b1;
  localparam logic HS_DEASSERT = 1'b0;

  // Accumulator control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;

  // A transfer happens when both sides agree in the same cycle.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage : approx_mult_pkg
`default_nettype wire

// File: rtl/approx_dot_accum.sv
`default_nettype none
// ============================================================================
//  Module      : approx_dot_accum
//  Description : Sums a programmed number of unsigned products from the
//                radix-4 approximate multiplier into a wide accumulator and
//                presents the result with a sticky carry-out flag.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                start, len      - begin a run of len products (IDLE only)
//                in_valid/ready  - product input handshake, in_prod data
//                out_valid/ready - result handshake, out_acc/out_ovf data
//                busy            - high while accumulating or holding result
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_dot_accum #(
  parameter int PROD_W = approx_mult_pkg::MULT_PROD_W,
  parameter int ACC_W  = 80,   // must be >= PROD_W
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  import approx_mult_pkg::*;

  acc_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  // One extra bit on the adder captures the carry out of the accumulator.
  logic [ACC_W:0]     prod_ext;
  logic [ACC_W:0]     sum_ext;
  logic               in_fire;
  logic               out_fire;

  // Handshake outputs depend on registered state only.
  always_comb begin
    in_ready  = (state_q == ST_ACCUM) ? HS_ASSERT : HS_DEASSERT;
    out_valid = (state_q == ST_DONE)  ? HS_ASSERT : HS_DEASSERT;
    busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  end

  assign in_fire  = hs_fire(in_valid, in_ready);
  assign out_fire = hs_fire(out_valid, out_ready);

  // Result registers double as the output; they keep their value in IDLE
  // until the next accepted start clears them.
  assign out_acc = acc_q;
  assign out_ovf = ovf_q;

  always_comb begin
    prod_ext                = '0;
    prod_ext[PROD_W-1:0]    = in_prod;
    sum_ext                 = {1'b0, acc_q} + prod_ext;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len;
          // A zero-length run has nothing to wait for: the cleared
          // accumulator is already the answer.
          state_d = (len == '0) ? ST_DONE : ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (in_fire) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          // cnt is never zero here (len==0 bypasses ACCUM), so the
          // decrement reaching zero coincides with leaving for DONE.
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (out_fire) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule : approx_dot_accum
`default_nettype wire

// File: tb/tb_approx_dot_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_approx_dot_accum
//  Description : Scoreboard bench for approx_dot_accum. Two instances share
//                all stimulus: the default 80-bit accumulator and a 64-bit
//                accumulator that exposes the carry-out flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_dot_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic [63:0] in_prod;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [79:0] out_acc_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [63:0] out_acc_b;

  approx_dot_accum #(.PROD_W(64), .ACC_W(80), .LEN_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_acc(out_acc_a), .out_ovf(out_ovf_a), .busy(busy_a)
  );

  approx_dot_accum #(.PROD_W(64), .ACC_W(64), .LEN_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_acc(out_acc_b), .out_ovf(out_ovf_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] acc;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [79:0] acc_a, input logic ovf_a,
                          input logic [63:0] acc_b, input logic ovf_b);
    exp_t e;
    e.acc = acc_a; e.ovf = ovf_a; q_a.push_back(e);
    e.acc = {16'h0, acc_b}; e.ovf = ovf_b; q_b.push_back(e);
  endtask

  // ---------------------------------------------------------------- monitors
  logic        prev_valid_a = 1'b0, prev_fire_a = 1'b0;
  logic [79:0] prev_acc_a   = '0;
  logic        prev_valid_b = 1'b0, prev_fire_b = 1'b0;
  logic [63:0] prev_acc_b   = '0;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst) begin
      prev_valid_a = 1'b0;
      prev_fire_a  = 1'b0;
    end else begin
      if (prev_valid_a && !prev_fire_a) begin
        check("hold_valid_a", {79'h0, out_valid_a}, 80'd1);
        check("hold_acc_a", out_acc_a, prev_acc_a);
      end
      if (out_valid_a && out_ready) begin
        if (q_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result_a: got %0h required none", out_acc_a);
        end else begin
          e = q_a.pop_front();
          check("result_acc_a", out_acc_a, e.acc);
          check("result_ovf_a", {79'h0, out_ovf_a}, {79'h0, e.ovf});
        end
      end
      prev_valid_a = out_valid_a;
      prev_fire_a  = out_valid_a & out_ready;
      prev_acc_a   = out_acc_a;
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst) begin
      prev_valid_b = 1'b0;
      prev_fire_b  = 1'b0;
    end else begin
      if (prev_valid_b && !prev_fire_b) begin
        check("hold_valid_b", {79'h0, out_valid_b}, 80'd1);
        check("hold_acc_b", {16'h0, out_acc_b}, {16'h0, prev_acc_b});
      end
      if (out_valid_b && out_ready) begin
        if (q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result_b: got %0h required none", out_acc_b);
        end else begin
          e = q_b.pop_front();
          check("result_acc_b", {16'h0, out_acc_b}, e.acc);
          check("result_ovf_b", {79'h0, out_ovf_b}, {79'h0, e.ovf});
        end
      end
      prev_valid_b = out_valid_b;
      prev_fire_b  = out_valid_b & out_ready;
      prev_acc_b   = out_acc_b;
    end
  end

  // ---------------------------------------------------------------- stimulus
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic do_start(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [63:0] p, input bit last);
    int t = 0;
    in_valid = 1'b1;
    in_prod  = p;
    @(negedge clk);
    while (!in_ready_a && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_a) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready=0 required in_ready=1");
      @(posedge clk);
      #1 in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    check(last ? "latency_out_valid" : "mid_run_out_valid", {79'h0, out_valid_a}, {79'h0, last});
  endtask

  task automatic take(input int hold, input bit with_start);
    int t = 0;
    while (!out_valid_a && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    if (!out_valid_a) begin
      n_checks++; n_fail++;
      $display("FAIL take_timeout: got out_valid=0 required out_valid=1");
      return;
    end
    repeat (hold + 1) @(posedge clk);
    #1 out_ready = 1'b1;
    start     = with_start;
    len       = 16'd5;
    @(posedge clk);
    #1 out_ready = 1'b0;
    start     = 1'b0;
    check("idle_busy", {79'h0, busy_a}, 80'd0);
    check("idle_out_valid", {79'h0, out_valid_a}, 80'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0;
    in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {79'h0, out_valid_a}, 80'd0);
    check("rst_in_ready", {79'h0, in_ready_a}, 80'd0);
    check("rst_busy", {79'h0, busy_a}, 80'd0);
    check("rst_out_acc", out_acc_a, 80'd0);
    check("rst_out_ovf", {79'h0, out_ovf_a}, 80'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic sum, back-to-back; start offered during the DONE handshake
    push_exp(80'd600, 1'b0, 64'd600, 1'b0);
    do_start(16'd3);
    check("accum_busy", {79'h0, busy_a}, 80'd1);
    check("accum_in_ready", {79'h0, in_ready_a}, 80'd1);
    send(64'd100, 1'b0);
    send(64'd200, 1'b0);
    send(64'd300, 1'b1);
    check("basic_out_acc", out_acc_a, 80'd600);
    take(0, 1'b1);
    check("idle_retains_acc", out_acc_a, 80'd600);

    // Backpressure on both sides
    push_exp(80'd327687, 1'b0, 64'd327687, 1'b0);
    do_start(16'd2);
    send(64'd327680, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(64'd7, 1'b1);
    take(4, 1'b0);

    // Zero length
    push_exp(80'd0, 1'b0, 64'd0, 1'b0);
    do_start(16'd0);
    check("zero_out_valid", {79'h0, out_valid_a}, 80'd1);
    check("zero_in_ready", {79'h0, in_ready_a}, 80'd0);
    check("zero_out_acc", out_acc_a, 80'd0);
    take(0, 1'b0);

    // Overflow: wraps in the 64-bit instance, not in the 80-bit one
    push_exp(80'h1_0000_0000_0000_0001, 1'b0, 64'd1, 1'b1);
    do_start(16'd2);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'd2, 1'b1);
    check("ovf_flag_b", {79'h0, out_ovf_b}, 80'd1);
    take(0, 1'b0);
    push_exp(80'd5, 1'b0, 64'd5, 1'b0);
    do_start(16'd1);
    send(64'd5, 1'b1);
    take(0, 1'b0);

    // Asynchronous reset mid-run
    do_start(16'd4);
    send(64'd1, 1'b0);
    send(64'd2, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", {79'h0, out_valid_a}, 80'd0);
    check("midrst_busy", {79'h0, busy_a}, 80'd0);
    check("midrst_in_ready", {79'h0, in_ready_a}, 80'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    q_a.delete();
    q_b.delete();
    push_exp(80'd9, 1'b0, 64'd9, 1'b0);
    do_start(16'd1);
    send(64'd9, 1'b1);
    take(0, 1'b0);

    // start during ACCUM is ignored
    push_exp(80'd10, 1'b0, 64'd10, 1'b0);
    do_start(16'd2);
    send(64'd4, 1'b0);
    start = 1'b1;
    len   = 16'd10;
    @(posedge clk);
    #1 start = 1'b0;
    check("ign_start_busy", {79'h0, busy_a}, 80'd1);
    send(64'd6, 1'b1);
    take(0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_a_drained", 80'(q_a.size()), 80'd0);
    check("queue_b_drained", 80'(q_b.size()), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_approx_dot_accum
`default_nettype wire
